// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: applies the inverse S-box to all 16 bytes
// of a 128-bit state, BPC bytes per cycle, with valid/ready handshakes.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input state handshake (dataIn, byte i = dataIn[8i:8i+7])
//   out_valid/out_ready : result handshake (dataOut, same byte ordering)
//   busy              : high while a state is being processed or waiting in DONE
module aes_inv_sub_bytes_seq #(
  parameter int unsigned BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] dataIn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] dataOut,
  output logic         busy
);

  localparam int unsigned NGRP = 16 / BPC;
  localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  // Inverse S-box, entry x at bits [8x +: 8].
  localparam logic [0:2047] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic [0:127]    work, work_nxt;
  logic [7:0]      lane_in  [BPC];
  logic [7:0]      lane_out [BPC];

  assign cnt_last = (cnt == CW'(NGRP - 1));

  // BPC lookup lanes, muxed onto the group selected by cnt.
  always_comb begin
    work_nxt = work;
    for (int unsigned l = 0; l < BPC; l++) begin
      lane_in[l]  = work[(32'(cnt) * BPC + l) * 8 +: 8];
      lane_out[l] = inv_sbox(lane_in[l]);
      work_nxt[(32'(cnt) * BPC + l) * 8 +: 8] = lane_out[l];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (cnt_last)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs depend on state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Work register and group counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= dataIn;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work <= work_nxt;
          cnt  <= cnt_last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign dataOut = work;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Scoreboard bench for aes_inv_sub_bytes_seq with three instances (BPC=4,1,16).
// The reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_sub_bytes_seq;

  typedef logic [0:127] st_t;
  typedef struct {
    st_t data;
    int  acc;
  } exp_t;

  localparam int NG [3] = '{4, 16, 1};

  logic clk, rst;
  logic iv   [3];
  logic ir   [3];
  logic ov   [3];
  logic ordy [3];
  logic bsy  [3];
  st_t  din  [3];
  st_t  dout [3];

  exp_t q [3][$];
  logic seen [3];
  st_t  hold [3];

  int cyc;
  int n_chk, n_pass;

  logic [7:0] fwd  [256];
  logic [7:0] invm [256];

  aes_inv_sub_bytes_seq #(.BPC(4)) dut_b4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .dataIn(din[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .dataOut(dout[0]), .busy(bsy[0]));
  aes_inv_sub_bytes_seq #(.BPC(1)) dut_b1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .dataIn(din[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .dataOut(dout[1]), .busy(bsy[1]));
  aes_inv_sub_bytes_seq #(.BPC(16)) dut_b16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .dataIn(din[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .dataOut(dout[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    if (x == 8'h00) b = 8'h00;
    else for (int i = 0; i < 254; i++) b = gmul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic st_t inv_state(input st_t s);
    st_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = invm[s[8*i +: 8]];
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) seen[k] = 1'b0;
      else if (ov[k]) begin
        if (!seen[k]) begin
          if (q[k].size() == 0) fail_now($sformatf("unexpected_out_valid[%0d]", k));
          else begin
            exp_t e;
            e = q[k].pop_front();
            chk($sformatf("data[%0d]", k), dout[k], e.data);
            chk($sformatf("latency[%0d]", k), 128'(cyc - e.acc), 128'(NG[k]));
            chk($sformatf("busy_done[%0d]", k), 128'(bsy[k]), 128'(1));
            chk($sformatf("in_ready_done[%0d]", k), 128'(ir[k]), 128'(0));
          end
          seen[k] = 1'b1;
          hold[k] = dout[k];
        end else begin
          chk($sformatf("stable[%0d]", k), dout[k], hold[k]);
        end
        if (ordy[k]) seen[k] = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int k, input st_t d, input st_t e);
    int  n;
    bit  done;
    exp_t t;
    n = 0; done = 0;
    @(posedge clk); #1;
    iv[k] = 1'b1; din[k] = d;
    while (!done) begin
      @(negedge clk);
      if (ir[k]) begin
        t.data = e; t.acc = cyc + 1;
        q[k].push_back(t);
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          fail_now($sformatf("accept_timeout[%0d]", k));
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    iv[k] = 1'b0; din[k] = rand_state();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 || ov[0] || ov[1] || ov[2]) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        fail_now("drain_timeout");
        for (int k = 0; k < 3; k++) q[k].delete();
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    st_t d, e;
    logic [7:0] orig [208];
    int n;

    n_chk = 0; n_pass = 0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; din[k] = '0; seen[k] = 1'b0; hold[k] = '0;
    end
    for (int x = 0; x < 256; x++) fwd[x] = sbox_model(8'(x));
    for (int x = 0; x < 256; x++) invm[fwd[x]] = 8'(x);

    // reset asserted mid-cycle takes effect immediately
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), 128'(ir[k]), 128'(1));
      chk($sformatf("rst_out_valid[%0d]", k), 128'(ov[k]), 128'(0));
      chk($sformatf("rst_busy[%0d]", k), 128'(bsy[k]), 128'(0));
      chk($sformatf("rst_dataOut[%0d]", k), dout[k], '0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 128'(ir[0]), 128'(1));
      chk("idle_out_valid", 128'(ov[0]), 128'(0));
      chk("idle_dataOut", dout[0], '0);
    end

    // FIPS-197 row vector
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    drain();

    // anchor bytes on all three widths
    for (int k = 0; k < 3; k++) begin
      send(k, 128'h0016ed5263636363636363637c7c7c7c, 128'h52ff5348000000000000000001010101);
      drain();
    end

    // round trip through the forward model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 208; i++) orig[i] = 8'($urandom);
      for (int s = 0; s < 13; s++) begin
        for (int b = 0; b < 16; b++) begin
          d[8*b +: 8] = fwd[orig[s*16 + b]];
          e[8*b +: 8] = orig[s*16 + b];
        end
        send(k, d, e);
      end
      drain();
    end

    // random states against the inverse model
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin
        d = rand_state();
        send(k, d, inv_state(d));
      end
      drain();
    end

    // backpressure with ignored input traffic
    @(posedge clk); #1 ordy[0] = 1'b0;
    d = rand_state();
    send(0, d, inv_state(d));
    n = 0;
    while (!ov[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ov[0]) fail_now("bp_out_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      iv[0] = ~iv[0];
      din[0] = rand_state();
      @(negedge clk);
      chk("bp_in_ready", 128'(ir[0]), 128'(0));
      chk("bp_out_valid", 128'(ov[0]), 128'(1));
    end
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 128'(ir[0]), 128'(1));
    chk("bp_idle_out_valid", 128'(ov[0]), 128'(0));
    d = rand_state();
    send(0, d, inv_state(d));
    drain();

    // reset two cycles after acceptance
    d = rand_state();
    send(0, d, inv_state(d));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    q[0].delete();
    chk("mid_rst_in_ready", 128'(ir[0]), 128'(1));
    chk("mid_rst_out_valid", 128'(ov[0]), 128'(0));
    chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
    chk("mid_rst_dataOut", dout[0], '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_out_valid", 128'(ov[0]), 128'(0));
      chk("post_rst_in_ready", 128'(ir[0]), 128'(1));
    end
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
